decode_lock_window: RTL and testbench

Parametrised lock-mask window decoder for sensor lane deskew calibration. It takes a MASK_W-bit lock mask, where bit i = 1 means delay tap i locked, and scans it one bit per cycle. It reports the longest contiguous run of ones as min tap, max tap, range and centre tap, plus a valid flag. An optional circular mode lets a run wrap from tap MASK_W-1 to tap 0. It sits between the per-lane tap sweep and the delay-tap programming logic in the sensor front end.

---
 rtl/decode_lock_window.sv | 161 ++++++++++++++++
 tb/tb_decode_lock_window.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/decode_lock_window.sv
// Lock-mask window decoder: scans a tap lock mask one bit per cycle and reports
// the longest contiguous run of locked taps (min, max, range, centre), optionally circular.
//
// state | meaning
// IDLE  | waiting for start; results held
// SCAN  | one mask bit per cycle, tracking current and best runs
// FINAL | convert best run into tap outputs, pulse done_out
// DONE  | one cycle of recovery before accepting the next start
module decode_lock_window #(
  parameter int MASK_W    = 32,
  parameter bit WRAP_EN   = 1'b0,
  parameter int MIN_RANGE = 1,
  localparam int IDX_W    = $clog2(MASK_W),
  localparam int RNG_W    = $clog2(MASK_W + 1)
) (
  input  logic              px_clk,
  input  logic              px_reset_n,
  input  logic              start,
  input  logic              clear,
  input  logic [MASK_W-1:0] lock_mask_din,
  output logic              busy_out,
  output logic [IDX_W-1:0]  delay_min_dout,
  output logic [IDX_W-1:0]  delay_max_dout,
  output logic [RNG_W-1:0]  delay_range_dout,
  output logic [IDX_W-1:0]  delay_center_dout,
  output logic              valid_out,
  output logic              done_out
);

  localparam int SCAN_N = WRAP_EN ? (2 * MASK_W - 1) : MASK_W;
  localparam int CNT_W  = $clog2(2 * MASK_W);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_N - 1);
  localparam logic [IDX_W-1:0] TAP_LAST  = IDX_W'(MASK_W - 1);
  localparam logic [RNG_W-1:0] LEN_MAX   = RNG_W'(MASK_W);
  localparam logic [RNG_W-1:0] LEN_OK    = RNG_W'(MIN_RANGE);
  localparam logic [RNG_W:0]   ONE_S     = (RNG_W + 1)'(1);
  localparam logic [RNG_W:0]   MASK_S    = (RNG_W + 1)'(MASK_W);

  typedef enum logic [1:0] {IDLE, SCAN, FINAL, DONE} state_t;

  state_t             state;
  logic [MASK_W-1:0]  mask_q;
  logic [CNT_W-1:0]   scan_cnt;
  logic [IDX_W-1:0]   tap;
  logic [RNG_W-1:0]   cur_len;
  logic [IDX_W-1:0]   cur_start;
  logic [RNG_W-1:0]   best_len;
  logic [IDX_W-1:0]   best_start;

  logic               bit_now;
  logic [RNG_W-1:0]   len_nxt;
  logic [IDX_W-1:0]   start_nxt;
  logic               take_best;

  logic [RNG_W:0]     start_s;
  logic [RNG_W:0]     last_ofs;
  logic [RNG_W:0]     end_raw;
  logic [RNG_W:0]     mid_raw;
  logic [IDX_W-1:0]   max_tap;
  logic [IDX_W-1:0]   mid_tap;

  // Run tracking; run length saturates at MASK_W so the second wrap pass cannot outgrow a full ring.
  always_comb begin
    bit_now   = mask_q[tap];
    len_nxt   = '0;
    start_nxt = cur_start;
    if (bit_now) begin
      if (cur_len == '0) start_nxt = tap;
      len_nxt = (cur_len == LEN_MAX) ? cur_len : cur_len + 1'b1;
    end
    take_best = (len_nxt > best_len);
  end

  // Both sums stay below 2*MASK_W, so one conditional subtract gives the modulo for any MASK_W.
  always_comb begin
    start_s  = (RNG_W + 1)'(best_start);
    last_ofs = {1'b0, best_len} - ONE_S;
    end_raw  = start_s + last_ofs;
    mid_raw  = start_s + (last_ofs >> 1);
    if (end_raw >= MASK_S) end_raw = end_raw - MASK_S;
    if (mid_raw >= MASK_S) mid_raw = mid_raw - MASK_S;
    max_tap  = IDX_W'(end_raw);
    mid_tap  = IDX_W'(mid_raw);
  end

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      state             <= IDLE;
      mask_q            <= '0;
      scan_cnt          <= '0;
      tap               <= '0;
      cur_len           <= '0;
      cur_start         <= '0;
      best_len          <= '0;
      best_start        <= '0;
      busy_out          <= 1'b0;
      delay_min_dout    <= '0;
      delay_max_dout    <= '0;
      delay_range_dout  <= '0;
      delay_center_dout <= '0;
      valid_out         <= 1'b0;
      done_out          <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (clear) begin
        state    <= IDLE;
        busy_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mask_q     <= lock_mask_din;
              scan_cnt   <= SCAN_LAST;
              tap        <= '0;
              cur_len    <= '0;
              cur_start  <= '0;
              best_len   <= '0;
              best_start <= '0;
              busy_out   <= 1'b1;
              state      <= SCAN;
            end
          end
          SCAN: begin
            cur_len   <= len_nxt;
            cur_start <= start_nxt;
            if (take_best) begin
              best_len   <= len_nxt;
              best_start <= start_nxt;
            end
            tap <= (tap == TAP_LAST) ? '0 : tap + 1'b1;
            if (scan_cnt == '0) state <= FINAL;
            else                scan_cnt <= scan_cnt - 1'b1;
          end
          FINAL: begin
            delay_range_dout <= best_len;
            if (best_len == '0) begin
              delay_min_dout    <= '0;
              delay_max_dout    <= '0;
              delay_center_dout <= '0;
              valid_out         <= 1'b0;
            end else begin
              delay_min_dout    <= best_start;
              delay_max_dout    <= max_tap;
              delay_center_dout <= mid_tap;
              valid_out         <= (best_len >= LEN_OK);
            end
            done_out <= 1'b1;
            busy_out <= 1'b0;
            state    <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_lock_window.sv
// Directed bench for decode_lock_window: four instances (linear, wrap, MIN_RANGE=6,
// 12-tap wrap) exercised one at a time with hand-computed results.
module tb_decode_lock_window;

  logic        px_clk = 1'b0;
  logic        px_reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  start_v = '0;
  logic [31:0] mask = '0;

  logic [3:0]  busy_v, done_v, valid_v;
  logic [4:0]  mn0, mx0, ct0, mn1, mx1, ct1, mn2, mx2, ct2;
  logic [5:0]  rg0, rg1, rg2;
  logic [3:0]  mn3, mx3, ct3, rg3;

  int sel;
  int o_min, o_max, o_rng, o_ctr;
  int tests = 0;
  int fails = 0;
  int cyc;

  always #5 px_clk = ~px_clk;

  decode_lock_window #(.MASK_W(32), .WRAP_EN(1'b0), .MIN_RANGE(1)) u_lin (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .start(start_v[0]), .clear(clear),
    .lock_mask_din(mask), .busy_out(busy_v[0]), .delay_min_dout(mn0), .delay_max_dout(mx0),
    .delay_range_dout(rg0), .delay_center_dout(ct0), .valid_out(valid_v[0]), .done_out(done_v[0]));

  decode_lock_window #(.MASK_W(32), .WRAP_EN(1'b1), .MIN_RANGE(1)) u_wrp (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .start(start_v[1]), .clear(clear),
    .lock_mask_din(mask), .busy_out(busy_v[1]), .delay_min_dout(mn1), .delay_max_dout(mx1),
    .delay_range_dout(rg1), .delay_center_dout(ct1), .valid_out(valid_v[1]), .done_out(done_v[1]));

  decode_lock_window #(.MASK_W(32), .WRAP_EN(1'b0), .MIN_RANGE(6)) u_min6 (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .start(start_v[2]), .clear(clear),
    .lock_mask_din(mask), .busy_out(busy_v[2]), .delay_min_dout(mn2), .delay_max_dout(mx2),
    .delay_range_dout(rg2), .delay_center_dout(ct2), .valid_out(valid_v[2]), .done_out(done_v[2]));

  decode_lock_window #(.MASK_W(12), .WRAP_EN(1'b1), .MIN_RANGE(1)) u_w12 (
    .px_clk(px_clk), .px_reset_n(px_reset_n), .start(start_v[3]), .clear(clear),
    .lock_mask_din(mask[11:0]), .busy_out(busy_v[3]), .delay_min_dout(mn3), .delay_max_dout(mx3),
    .delay_range_dout(rg3), .delay_center_dout(ct3), .valid_out(valid_v[3]), .done_out(done_v[3]));

  always_comb begin
    o_min = 0; o_max = 0; o_rng = 0; o_ctr = 0;
    case (sel)
      0: begin o_min = int'(mn0); o_max = int'(mx0); o_rng = int'(rg0); o_ctr = int'(ct0); end
      1: begin o_min = int'(mn1); o_max = int'(mx1); o_rng = int'(rg1); o_ctr = int'(ct1); end
      2: begin o_min = int'(mn2); o_max = int'(mx2); o_rng = int'(rg2); o_ctr = int'(ct2); end
      default: begin o_min = int'(mn3); o_max = int'(mx3); o_rng = int'(rg3); o_ctr = int'(ct3); end
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int s, input logic [31:0] m);
    @(negedge px_clk);
    sel = s;
    mask = m;
    start_v[s] = 1'b1;
    @(posedge px_clk);
    #1 start_v[s] = 1'b0;
  endtask

  // Returns edges counted until done_out is seen, or -1 on timeout.
  task automatic wait_done(input int s, output int n);
    n = 0;
    while (done_v[s] !== 1'b1 && n < 200) begin
      @(posedge px_clk);
      #1 n++;
    end
    if (done_v[s] !== 1'b1) n = -1;
  endtask

  task automatic run(input string tag, input int s, input logic [31:0] m, input int lat,
                     input int emin, input int emax, input int erng, input int ectr, input int evld);
    int n;
    pulse(s, m);
    chk({tag, " busy"}, int'(busy_v[s]), 1);
    wait_done(s, n);
    chk({tag, " latency"}, n, lat);
    chk({tag, " min"}, o_min, emin);
    chk({tag, " max"}, o_max, emax);
    chk({tag, " range"}, o_rng, erng);
    chk({tag, " center"}, o_ctr, ectr);
    chk({tag, " valid"}, int'(valid_v[s]), evld);
    chk({tag, " busy at done"}, int'(busy_v[s]), 0);
    @(posedge px_clk);
    #1 chk({tag, " done width"}, int'(done_v[s]), 0);
  endtask

  initial begin
    int dcount;
    sel = 0;
    #12;
    chk("reset range", int'(rg0), 0);
    chk("reset done", int'(done_v[0]), 0);
    chk("reset busy", int'(busy_v[0]), 0);
    @(negedge px_clk) px_reset_n = 1'b1;

    run("lin ff0000", 0, 32'h00FF_0000, 33, 16, 23, 8, 19, 1);
    run("lin tie",    0, 32'hF000_000F, 33, 0, 3, 4, 1, 1);
    run("wrp wrap",   1, 32'hF000_000F, 64, 28, 3, 8, 31, 1);
    run("lin zero",   0, 32'h0000_0000, 33, 0, 0, 0, 0, 0);
    run("lin ones",   0, 32'hFFFF_FFFF, 33, 0, 31, 32, 15, 1);
    run("wrp ones",   1, 32'hFFFF_FFFF, 64, 0, 31, 32, 15, 1);
    run("min6 1f",    2, 32'h0000_001F, 33, 0, 4, 5, 2, 0);
    run("w12 c03",    3, 32'h0000_0C03, 24, 10, 1, 4, 11, 1);

    // run 1 then an aborted run 2: results of run 1 must survive
    run("lin run1",   0, 32'h00FF_0000, 33, 16, 23, 8, 19, 1);
    pulse(0, 32'h0000_F000);
    repeat (9) @(posedge px_clk);
    @(negedge px_clk) clear = 1'b1;
    @(posedge px_clk);
    #1 clear = 1'b0;
    chk("clear busy", int'(busy_v[0]), 0);
    dcount = 0;
    repeat (40) begin
      @(posedge px_clk);
      #1 if (done_v[0] === 1'b1) dcount++;
    end
    chk("clear no done", dcount, 0);
    chk("clear held min", o_min, 16);
    chk("clear held range", o_rng, 8);
    chk("clear held center", o_ctr, 19);

    // start while busy must be ignored, along with the mask on that edge
    pulse(0, 32'h0000_00F0);
    repeat (4) @(posedge px_clk);
    pulse(0, 32'h0F00_0000);
    wait_done(0, cyc);
    chk("ignored start latency", cyc, 28);
    chk("ignored start min", o_min, 4);
    chk("ignored start max", o_max, 7);
    chk("ignored start range", o_rng, 4);
    chk("ignored start center", o_ctr, 5);

    // asynchronous reset during a scan
    @(posedge px_clk);
    pulse(0, 32'h0000_00FF);
    repeat (5) @(posedge px_clk);
    @(negedge px_clk) px_reset_n = 1'b0;
    #1;
    chk("async rst min", o_min, 0);
    chk("async rst range", o_rng, 0);
    chk("async rst center", o_ctr, 0);
    chk("async rst busy", int'(busy_v[0]), 0);
    chk("async rst valid", int'(valid_v[0]), 0);
    @(negedge px_clk) px_reset_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge px_clk);
      #1 if (done_v[0] === 1'b1) dcount++;
    end
    chk("async rst no done", dcount, 0);

    run("b2b a", 0, 32'h0000_0FF0, 33, 4, 11, 8, 7, 1);
    run("b2b b", 0, 32'h0000_0003, 33, 0, 1, 2, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
